adder_rr_scheduler: RTL and testbench

Shares one WIDTH-bit adder datapath (sum of two byte operands) among NREQ requesters using round-robin arbitration.
- Each requester presents an operand pair with a valid/ready handshake.
- The block grants one requester per cycle, computes the sum, and holds it with the winner's ID in a single-entry output register until the consumer accepts it.
- Sits between the pin-level input muxing and the output pins of the tile.

---
 rtl/adder_rr_scheduler.sv | 127 ++++++++++++
 tb/tb_adder_rr_scheduler.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/adder_rr_scheduler.sv
//------------------------------------------------------------------------------
// Module  : adder_rr_scheduler
// Brief   : Round-robin sharing of one WIDTH-bit adder across NREQ requesters,
//           result held in a single-entry output register. Optional macro
//           ADDER_RR_SAT_EN saturates out_sum on carry-out.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module adder_rr_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_sum,
  output logic                  out_carry,
  output logic [IDW-1:0]        out_id,
  output logic                  busy
);

  localparam logic [IDW-1:0] c_LAST = IDW'(NREQ - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t r_state, w_state_nxt;

  logic [IDW-1:0]   r_ptr;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [IDW-1:0]   r_id;

  logic             w_slot_free;
  logic             w_found;
  logic             w_grant_any;
  logic [IDW-1:0]   w_gid;
  logic [NREQ-1:0]  w_grant;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic [WIDTH:0]   w_sum_full;
  logic [WIDTH-1:0] w_sum_final;

  assign w_slot_free = (r_state == EMPTY) || out_ready;

  // Scan from the pointer, wrapping modulo NREQ; first asserted request wins.
  always_comb begin
    w_found = 1'b0;
    w_gid   = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = int'(r_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_gid   = IDW'(idx);
      end
    end
  end

  assign w_grant_any = w_found && w_slot_free && !rst;

  always_comb begin
    w_grant = '0;
    if (w_grant_any) w_grant[w_gid] = 1'b1;
  end

  assign w_sel_a    = req_a[w_gid*WIDTH +: WIDTH];
  assign w_sel_b    = req_b[w_gid*WIDTH +: WIDTH];
  assign w_sum_full = {1'b0, w_sel_a} + {1'b0, w_sel_b};

`ifdef ADDER_RR_SAT_EN
  assign w_sum_final = w_sum_full[WIDTH] ? {WIDTH{1'b1}} : w_sum_full[WIDTH-1:0];
`else
  assign w_sum_final = w_sum_full[WIDTH-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= EMPTY;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY: if (w_grant_any) w_state_nxt = FULL;
      FULL: begin
        if (w_grant_any)    w_state_nxt = FULL;
        else if (out_ready) w_state_nxt = EMPTY;
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_id    <= '0;
    end else if (w_grant_any) begin
      r_ptr   <= (w_gid == c_LAST) ? '0 : w_gid + 1'b1;
      r_sum   <= w_sum_final;
      r_carry <= w_sum_full[WIDTH];
      r_id    <= w_gid;
    end
  end

  assign req_ready = w_grant;
  assign out_valid = (r_state == FULL);
  assign out_sum   = r_sum;
  assign out_carry = r_carry;
  assign out_id    = r_id;
  assign busy      = out_valid || (|req_valid);

endmodule

`default_nettype wire

// File: tb/tb_adder_rr_scheduler.sv
//------------------------------------------------------------------------------
// Module  : tb_adder_rr_scheduler
// Brief   : Self-checking bench for adder_rr_scheduler (NREQ=4, WIDTH=8).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_adder_rr_scheduler;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_sum;
  logic                  out_carry;
  logic [IDW-1:0]        out_id;
  logic                  busy;

  adder_rr_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_id    (out_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state: a held result (or none) and the priority pointer.
  int m_ptr   = 0;
  bit m_valid = 0;
  int m_sum   = 0;
  int m_carry = 0;
  int m_id    = 0;
  int last_grant;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int winner(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic step(input logic [NREQ-1:0] v, input logic [31:0] a, input logic [31:0] b,
                      input logic o, input logic r);
    int w, tot;
    bit slot;
    @(negedge clk);
    req_valid = v; req_a = a; req_b = b; out_ready = o; rst = r;
    #1;
    w    = winner(v);
    slot = !m_valid || o;
    last_grant = (!r && slot && w >= 0) ? (1 << w) : 0;
    check("req_ready", 32'(req_ready), 32'(last_grant));
    check("busy", 32'(busy), 32'(m_valid || (|v)));
    @(posedge clk);
    #1;
    if (r) begin
      m_valid = 0; m_ptr = 0; m_sum = 0; m_carry = 0; m_id = 0;
    end else if (last_grant != 0) begin
      tot     = int'(a[w*WIDTH +: WIDTH]) + int'(b[w*WIDTH +: WIDTH]);
      m_carry = (tot > 255) ? 1 : 0;
`ifdef ADDER_RR_SAT_EN
      m_sum   = (tot > 255) ? 255 : tot;
`else
      m_sum   = tot % 256;
`endif
      m_id    = w;
      m_valid = 1;
      m_ptr   = (w + 1) % NREQ;
    end else if (o) begin
      m_valid = 0;
    end
    check("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid || r) begin
      check("out_sum", 32'(out_sum), 32'(m_sum));
      check("out_carry", 32'(out_carry), 32'(m_carry));
      check("out_id", 32'(out_id), 32'(m_id));
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; out_ready = 1'b0;

    // 1: reset then idle
    step(4'b0000, 0, 0, 0, 1);
    step(4'b0000, 0, 0, 0, 1);
    step(4'b0000, 0, 0, 0, 0);
    check("t1_busy", 32'(busy), 0);

    // 2: single request from requester 1
    step(4'b0010, 32'h0000_1200, 32'h0000_3400, 1, 0);
    check("t2_grant", 32'(last_grant), 32'b0010);
    check("t2_sum", 32'(out_sum), 32'h46);
    check("t2_id", 32'(out_id), 1);

    // 3: fairness from a fresh pointer
    step(4'b0000, 0, 0, 1, 1);
    for (int i = 0; i < 8; i++) begin
      step(4'b1111, $urandom, $urandom, 1, 0);
      check("t3_order", 32'(last_grant), 32'(1 << (i % 4)));
      check("t3_id", 32'(out_id), 32'(i % 4));
    end

    // 4: backpressure with requester 2 waiting
    step(4'b0001, 32'h0000_0005, 32'h0000_0006, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(4'b0100, 32'h0011_0000, 32'h0022_0000, 0, 0);
      check("t4_stall_grant", 32'(last_grant), 0);
      check("t4_stall_sum", 32'(out_sum), 32'h0B);
    end
    step(4'b0100, 32'h0011_0000, 32'h0022_0000, 1, 0);
    check("t4_b2b_grant", 32'(last_grant), 32'b0100);
    check("t4_b2b_sum", 32'(out_sum), 32'h33);

    // 5: overflow
    step(4'b0001, 32'h0000_00F0, 32'h0000_0020, 1, 0);
    check("t5_carry", 32'(out_carry), 1);
`ifdef ADDER_RR_SAT_EN
    check("t5_sum", 32'(out_sum), 32'hFF);
`else
    check("t5_sum", 32'(out_sum), 32'h10);
`endif

    // 6: reset while a result is held, pointer parked at 2 beforehand
    step(4'b0010, 32'h0000_0100, 32'h0000_0200, 1, 0);
    step(4'b0000, 0, 0, 0, 0);
    step(4'b1010, 0, 0, 0, 1);
    check("t6_valid", 32'(out_valid), 0);
    step(4'b1010, 32'h0000_0700, 32'h0000_0800, 1, 0);
    check("t6_grant", 32'(last_grant), 32'b0010);

    // 7: randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom), $urandom, $urandom, ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 63) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
